// File: rtl/add_round_key_pkg.sv
// Shared AES-128 definitions: widths, round count, byte order and key addition.
package add_round_key_pkg;

  localparam int DATA_W     = 128;
  localparam int NR         = 10;
  localparam int NK_ENTRIES = NR + 1;
  localparam int NBYTES     = DATA_W / 8;

  // Round index 0..NR; also used as the key store address.
  typedef logic [3:0] rnd_t;

  localparam rnd_t LAST_RND = rnd_t'(NR);

  // Byte i of a state lives at bits [DATA_W-1-8i -: 8]; key addition is a
  // carry-free XOR of corresponding bytes.
  function automatic logic [DATA_W-1:0] add_key(input logic [DATA_W-1:0] state,
                                                input logic [DATA_W-1:0] key);
    logic [DATA_W-1:0] res;
    res = '0;
    for (int i = 0; i < NBYTES; i++) begin
      res[DATA_W-1-8*i -: 8] = state[DATA_W-1-8*i -: 8] ^ key[DATA_W-1-8*i -: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/add_round_key_round_key_store.sv
// Round key register file: NR+1 entries, write-tracking mask and keys_ready.
module add_round_key_round_key_store
  import add_round_key_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              keys_ready
);

  logic [DATA_W-1:0]     keys_q [NK_ENTRIES];
  logic [NK_ENTRIES-1:0] mask_d, mask_q;
  logic                  ready_d, ready_q;
  logic                  wr_hit;

  // Accept writes only to valid indices; readiness looks at the updated mask
  // so keys_ready rises the cycle right after the last missing write.
  always_comb begin
    wr_hit = wr_en && (wr_addr <= LAST_RND);
    mask_d = mask_q;
    if (wr_hit) begin
      mask_d[wr_addr] = 1'b1;
    end
    ready_d = &mask_d;
  end

  // Key contents are deliberately not reset; only the mask tracks validity.
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      keys_q[wr_addr] <= wr_data;
    end
  end

  // Write mask and ready flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mask_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      mask_q  <= mask_d;
      ready_q <= ready_d;
    end
  end

  // Combinational read returns pre-write contents on a same-cycle write.
  always_comb begin
    rd_data = '0;
    if (rd_idx <= LAST_RND) begin
      rd_data = keys_q[rd_idx];
    end
  end

  assign keys_ready = ready_q;

endmodule

// File: rtl/add_round_key.sv
// AddRoundKey stage with internal key store, round sequencing and error flag.
module add_round_key
  import add_round_key_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              key_wr_en,
  input  logic [3:0]        key_wr_addr,
  input  logic [DATA_W-1:0] key_wr_data,
  input  logic              valid_in,
  input  logic              block_start,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic [3:0]        round_out,
  output logic              last_out,
  output logic              keys_ready,
  output logic              seq_err
);

  rnd_t              rnd_d, rnd_q;
  rnd_t              round_d, round_q;
  rnd_t              key_idx;
  logic              valid_d, valid_q;
  logic              last_d, last_q;
  logic              err_d, err_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic [DATA_W-1:0] key_rd;

  add_round_key_round_key_store u_store (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (key_wr_en),
    .wr_addr    (key_wr_addr),
    .wr_data    (key_wr_data),
    .rd_idx     (key_idx),
    .rd_data    (key_rd),
    .keys_ready (keys_ready)
  );

  // Key index: round 0 for a block start or an out-of-sequence beat, else rnd.
  always_comb begin
    key_idx = '0;
    if (valid_in && !block_start) begin
      key_idx = rnd_q;
    end
  end

  // Round sequencing, protocol checking and output capture.
  always_comb begin
    rnd_d   = rnd_q;
    round_d = round_q;
    valid_d = 1'b0;
    last_d  = last_q;
    err_d   = err_q;
    data_d  = data_q;
    if (valid_in) begin
      valid_d = 1'b1;
      last_d  = 1'b0;
      data_d  = add_key(data_in, key_rd);
      if (block_start) begin
        round_d = '0;
        rnd_d   = rnd_t'(1);
        if (rnd_q != '0) begin
          err_d = 1'b1;
        end
      end else if (rnd_q != '0) begin
        round_d = rnd_q;
        if (rnd_q == LAST_RND) begin
          last_d = 1'b1;
          rnd_d  = '0;
        end else begin
          rnd_d = rnd_q + rnd_t'(1);
        end
      end else begin
        round_d = '0;
        err_d   = 1'b1;
      end
      if (!keys_ready) begin
        err_d = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rnd_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      rnd_q   <= rnd_d;
      round_q <= round_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign round_out = round_q;
  assign last_out  = last_q;
  assign seq_err   = err_q;

endmodule

// File: tb/tb_add_round_key.sv
// Self-checking bench for add_round_key with a behavioural reference model.
module tb_add_round_key;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         key_wr_en = 1'b0;
  logic [3:0]   key_wr_addr = '0;
  logic [127:0] key_wr_data = '0;
  logic         valid_in = 1'b0;
  logic         block_start = 1'b0;
  logic [127:0] data_in = '0;
  logic         valid_out;
  logic [127:0] data_out;
  logic [3:0]   round_out;
  logic         last_out;
  logic         keys_ready;
  logic         seq_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [127:0] mk [0:10];
  bit           written [0:10];
  bit           m_ready;
  int           pos;          // next round number expected for the current block
  bit           m_err;
  bit           ev, el;
  logic [127:0] ed;
  int           er;

  logic [127:0] fips_key, k1, knew, old3, d3;

  add_round_key dut (
    .clk         (clk),
    .reset       (reset),
    .key_wr_en   (key_wr_en),
    .key_wr_addr (key_wr_addr),
    .key_wr_data (key_wr_data),
    .valid_in    (valid_in),
    .block_start (block_start),
    .data_in     (data_in),
    .valid_out   (valid_out),
    .data_out    (data_out),
    .round_out   (round_out),
    .last_out    (last_out),
    .keys_ready  (keys_ready),
    .seq_err     (seq_err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] bytes_xor(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = a[127-8*i -: 8] ^ b[127-8*i -: 8];
    return r;
  endfunction

  task automatic check(input string tag);
    checks++;
    assert (valid_out === ev) else begin errors++; $error("FAIL %s valid_out got %0b exp %0b", tag, valid_out, ev); end
    checks++;
    assert (data_out === ed) else begin errors++; $error("FAIL %s data_out got %h exp %h", tag, data_out, ed); end
    checks++;
    assert (round_out === 4'(er)) else begin errors++; $error("FAIL %s round_out got %0d exp %0d", tag, round_out, er); end
    checks++;
    assert (last_out === el) else begin errors++; $error("FAIL %s last_out got %0b exp %0b", tag, last_out, el); end
    checks++;
    assert (keys_ready === m_ready) else begin errors++; $error("FAIL %s keys_ready got %0b exp %0b", tag, keys_ready, m_ready); end
    checks++;
    assert (seq_err === m_err) else begin errors++; $error("FAIL %s seq_err got %0b exp %0b", tag, seq_err, m_err); end
  endtask

  task automatic check_lit(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin errors++; $error("FAIL %s got %h exp %h", tag, got, exp); end
  endtask

  // Model one clock edge from the currently driven inputs, then compare.
  task automatic step(input string tag);
    int k;
    bit all;
    if (valid_in) begin
      ev = 1'b1;
      el = 1'b0;
      if (block_start) begin
        if (pos != 0) m_err = 1'b1;
        k = 0; er = 0; pos = 1;
      end else if (pos == 0) begin
        m_err = 1'b1;
        k = 0; er = 0;
      end else begin
        k = pos; er = pos;
        if (pos == 10) begin el = 1'b1; pos = 0; end
        else pos = pos + 1;
      end
      if (!m_ready) m_err = 1'b1;
      ed = bytes_xor(data_in, mk[k]);
    end else begin
      ev = 1'b0;
    end
    if (key_wr_en && key_wr_addr <= 4'd10) begin
      mk[key_wr_addr] = key_wr_data;
      written[key_wr_addr] = 1'b1;
    end
    all = 1'b1;
    for (int i = 0; i <= 10; i++) if (!written[i]) all = 1'b0;
    m_ready = all;
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    valid_in = 1'b0; block_start = 1'b0; key_wr_en = 1'b0;
    @(posedge clk);
    #1;
    ev = 0; ed = '0; er = 0; el = 0; m_ready = 0; m_err = 0; pos = 0;
    for (int i = 0; i <= 10; i++) written[i] = 1'b0;
    check(tag);
    reset = 1'b1;
  endtask

  task automatic wkey(input int idx, input logic [127:0] val);
    key_wr_en = 1'b1; key_wr_addr = 4'(idx); key_wr_data = val;
    step("key_write");
    key_wr_en = 1'b0;
  endtask

  task automatic beat(input bit start, input logic [127:0] d, input string tag);
    valid_in = 1'b1; block_start = start; data_in = d;
    step(tag);
    valid_in = 1'b0; block_start = 1'b0;
  endtask

  task automatic idle(input string tag);
    valid_in = 1'b0; block_start = 1'b0; key_wr_en = 1'b0;
    step(tag);
  endtask

  initial begin
    fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    k1       = 128'ha0fafe1788542cb123a339392a6c7605;
    ev = 0; ed = '0; er = 0; el = 0; m_ready = 0; m_err = 0; pos = 0;
    for (int i = 0; i <= 10; i++) begin mk[i] = '0; written[i] = 1'b0; end

    // Reset state
    @(posedge clk); #1;
    do_reset("reset_state");

    // FIPS-197 round-0 vector
    for (int i = 0; i <= 10; i++) wkey(i, fips_key);
    idle("after_load");
    beat(1'b1, 128'h3243f6a8885a308d313198a2e0370734, "fips_r0");
    check_lit("fips_r0_lit", data_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);

    // Round-1 vector
    do_reset("reset2");
    for (int i = 0; i <= 10; i++) wkey(i, fips_key);
    wkey(1, k1);
    beat(1'b1, 128'h3243f6a8885a308d313198a2e0370734, "r1_round0");
    beat(1'b0, 128'h046681e5e0cb199a48f8d37a2806264c, "r1_round1");
    check_lit("r1_lit", data_out, 128'ha49c7ff2689f352b6b5bea43026a5049);

    // Full 11-beat block with identity-pattern keys
    do_reset("reset3");
    for (int i = 0; i <= 10; i++) wkey(i, {16{8'(i)}});
    for (int i = 0; i <= 10; i++) beat(i == 0, '0, "full_block");
    check_lit("full_last_data", data_out, {16{8'd10}});
    idle("full_hold");
    beat(1'b1, '0, "full_restart_ok");

    // Out-of-sequence beat after reset, then a good block start
    do_reset("reset4");
    for (int i = 0; i <= 10; i++) wkey(i, {16{8'(i + 8'h30)}});
    idle("seq_wait");
    beat(1'b0, 128'h00112233445566778899aabbccddeeff, "seq_bad_beat");
    idle("seq_sticky");
    beat(1'b1, 128'h0f0e0d0c0b0a09080706050403020100, "seq_good_start");

    // Same-cycle key write vs read on index 3
    do_reset("reset5");
    for (int i = 0; i <= 10; i++) wkey(i, {4{32'($urandom)}});
    idle("wr_wait");
    knew = 128'hdeadbeef_0badf00d_cafebabe_12345678;
    old3 = mk[3];
    d3   = 128'h55555555aaaaaaaa55555555aaaaaaaa;
    beat(1'b1, '0, "wr_r0");
    beat(1'b0, '0, "wr_r1");
    beat(1'b0, '0, "wr_r2");
    key_wr_en = 1'b1; key_wr_addr = 4'd3; key_wr_data = knew;
    beat(1'b0, d3, "wr_r3_old");
    key_wr_en = 1'b0;
    check_lit("wr_r3_old_lit", data_out, d3 ^ old3);
    for (int i = 4; i <= 10; i++) beat(1'b0, 128'(i), "wr_tail");
    for (int i = 0; i <= 3; i++) beat(i == 0, d3, "wr_second");
    check_lit("wr_r3_new_lit", data_out, d3 ^ knew);

    // Randomised traffic with interleaved key writes, including illegal addresses
    do_reset("reset6");
    for (int i = 0; i <= 10; i++) wkey(i, {$urandom, $urandom, $urandom, $urandom});
    idle("rand_wait");
    for (int n = 0; n < 300; n++) begin
      valid_in    = ($urandom_range(0, 3) != 0);
      block_start = valid_in && ((pos == 0) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 31) == 0));
      data_in     = {$urandom, $urandom, $urandom, $urandom};
      key_wr_en   = ($urandom_range(0, 9) == 0);
      key_wr_addr = 4'($urandom_range(0, 15));
      key_wr_data = {$urandom, $urandom, $urandom, $urandom};
      step("random");
    end
    idle("rand_end");

    // Reset mid-block, then a beat before keys are reloaded
    do_reset("reset7");
    for (int i = 0; i <= 10; i++) wkey(i, {16{8'(8'hA0 + i)}});
    for (int i = 0; i <= 5; i++) beat(i == 0, 128'(i * 7), "mid_block");
    do_reset("mid_reset");
    beat(1'b1, 128'h1234, "no_keys_beat");
    idle("no_keys_hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_round_key.md
# add_round_key

Final stage of each AES-128 encryption round. It consumes the 128-bit state from MixColumns, or the round-0 plaintext, and XORs it with the round key for the current round. Round keys come from an internal 11-entry key store, loaded through a write port. A round counter tracks where each block is in its 0..NR sequence, so downstream control needs no round bookkeeping of its own.

## Interface
- DATA_W, 128, state and round-key width
- NR, 10, number of rounds; key store holds NR+1 entries
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-low
- key_wr_en  in  1  write strobe for key store
- key_wr_addr  in  4  key index 0..NR; values > NR ignored
- key_wr_data  in  DATA_W  round key; byte 0 in bits [127:120]
- valid_in  in  1  data_in valid this cycle
- block_start  in  1  qualifies valid_in: data_in is round-0 input of a new block
- data_in  in  DATA_W  state; byte 0 in bits [127:120]
- valid_out  out  1  registered valid
- data_out  out  DATA_W  data_in XOR selected round key
- round_out  out  4  round index applied to data_out
- last_out  out  1  data_out is the final-round (round NR) result
- keys_ready  out  1  all NR+1 key entries written since reset
- seq_err  out  1  sticky protocol error flag

## Operation
- Key store: NR+1 × DATA_W registers; contents not reset. A write mask of NR+1 bits is cleared on reset. keys_ready is the AND of the mask, registered.
- Round counter rnd (4 bits, 0..NR), reset to 0. The key is selected from rnd as follows, evaluated on each accepted valid_in:
  - block_start=1: use key[0]; round_out<=0; rnd<=1. This applies regardless of the current rnd (restart).
  - block_start=0 and rnd≠0: use key[rnd]; round_out<=rnd. If rnd==NR, then last_out<=1 and rnd<=0; otherwise rnd<=rnd+1.
  - block_start=0 and rnd==0: protocol error. Set seq_err<=1, use key[0], round_out<=0, rnd stays 0.
- A restart while rnd≠0 (block_start mid-block) also sets seq_err. The previous block is abandoned.
- valid_in while keys_ready==0 sets seq_err. The data is still processed with the current register contents.
- No valid_in: data_out, round_out and last_out hold their values; valid_out<=0.
- seq_err clears only on reset.
- Same-cycle key write and read of one index: the XOR uses the old contents. The new key is visible from the next cycle.
- Key write to an index > NR: no effect on the store or mask, and no error.
- XOR is bytewise over the full width. There is no arithmetic carry.

## Timing
- Latency is 1 cycle from valid_in to valid_out. Throughput is one state per cycle with no back-pressure.
- Reset values: valid_out=0, data_out=0, round_out=0, last_out=0, keys_ready=0, seq_err=0, rnd=0, write mask=0.
- Reset asserted mid-block: on the next edge all the above return to reset values. In-flight data is dropped, and keys must be reloaded before keys_ready rises again.
- keys_ready rises in the cycle after the final missing key write.
- last_out and round_out are registered alongside data_out and valid only while valid_out=1.

## Structure
- Shared AES package: DATA_W, NR, NK_ENTRIES=NR+1, the byte-order convention (byte i at bits [127-8i -: 8]), and a round-index type.
- One sub-module is natural: round_key_store. It holds the register array, the write mask and keys_ready, and provides a combinational read by index.
- The top level holds the counter, error logic and output registers.

## Test plan
- Load FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c at index 0 and all other indices, then send block_start with data_in 3243f6a8885a308d313198a2e0370734 -> next cycle data_out=193de3bea0f4e22b9ac68d2ae9f84808, round_out=0, last_out=0, seq_err=0.
- Load key[1]=a0fafe1788542cb123a339392a6c7605, then apply the round-0 beat followed by valid_in with data_in 046681e5e0cb199a48f8d37a2806264c -> data_out=a49c7ff2689f352b6b5bea43026a5049, round_out=1.
- Send 11 back-to-back beats (first with block_start) with keys[i]=i replicated per byte, data_in=0 -> round_out 0..10, last_out only on the 11th, then rnd returns to 0.
- Send valid_in without block_start after reset with keys loaded -> seq_err=1 and stays high; a later block_start beat still produces correct output.
- Write key[3] with new value K in the same cycle as a round-3 beat -> that beat uses the old key[3]; the next round-3 beat uses K.
- Assert reset after round 5 -> all outputs 0 and keys_ready=0; a beat sent before reloading keys sets seq_err.
